// File: rtl/hack_fetch_sequencer_pkg.sv
// Shared types and default sizing for the Hack fetch sequencer.
package hack_seq_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/hack_fetch_sequencer_if.sv
// ROM fetch, execute issue and program-counter control bundle.
interface hack_fetch_sequencer_if
    import hack_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  rom_req;
    logic [DATA_WIDTH-1:0] rom_addr;
    logic                  rom_ack;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_ready;
    logic                  br_taken;
    logic [DATA_WIDTH-1:0] br_target;
    logic                  pc_load;
    logic                  pc_incr;
    logic [DATA_WIDTH-1:0] pc_in;
    logic [DATA_WIDTH-1:0] pc_value;

    modport master (
        output rom_req, rom_addr, instr_valid, instr, pc_load, pc_incr, pc_in,
        input  rom_ack, rom_data, instr_ready, br_taken, br_target, pc_value
    );

    modport slave (
        input  rom_req, rom_addr, instr_valid, instr, pc_load, pc_incr, pc_in,
        output rom_ack, rom_data, instr_ready, br_taken, br_target, pc_value
    );
endinterface

// File: rtl/hack_fetch_sequencer_timer.sv
// Saturating count of consecutive unacknowledged fetch cycles.
module hack_wait_timer
    import hack_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    // Flags the cycle that would be the last one allowed, so the FSM
    // can leave on the edge that ends it; an ack that cycle still wins.
    assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/hack_fetch_sequencer.sv
// Fetch/issue sequencer: fetches at pc_value, issues to execute, steers the PC.
module hack_fetch_sequencer
    import hack_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic step,
    input  logic fault_clr,
    output logic halted,
    output logic fault,
    hack_fetch_sequencer_if.master bus
);
    seq_state_t            state, next_state;
    logic                  one_shot;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  fire;
    logic                  tmr_expired;

    assign fire = (state == ISSUE) && bus.instr_ready;

    hack_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  ((state == FETCH) && !bus.rom_ack),
        .clear   ((state != FETCH) || bus.rom_ack),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (run || step) next_state = FETCH;
            FETCH: begin
                if (bus.rom_ack)      next_state = ISSUE;
                else if (tmr_expired) next_state = FAULT;
            end
            ISSUE: if (fire) next_state = (run && !one_shot) ? FETCH : IDLE;
            FAULT: if (fault_clr) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        halted          = (state == IDLE);
        fault           = (state == FAULT);
        bus.rom_req     = (state == FETCH);
        bus.rom_addr    = bus.pc_value;
        bus.instr_valid = (state == ISSUE);
        bus.pc_load     = fire && bus.br_taken;
        bus.pc_incr     = fire && !bus.br_taken;
        bus.pc_in       = (fire && bus.br_taken) ? bus.br_target : '0;
    end

    // A step only arms the one-shot when run is not already requesting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            one_shot <= 1'b0;
            instr_q  <= '0;
        end else begin
            if (state == IDLE && !run && step)
                one_shot <= 1'b1;
            else if ((state == ISSUE && fire) || state == FAULT)
                one_shot <= 1'b0;
            if (state == FETCH && bus.rom_ack)
                instr_q <= bus.rom_data;
        end
    end

    assign bus.instr = instr_q;

endmodule

// File: doc/hack_fetch_sequencer.md
# hack_fetch_sequencer

Fetch/issue controller for the Hack CPU that sequences the program counter. It reads the current PC, fetches the instruction from instruction ROM over a req/ack handshake, and hands the instruction to the execute stage over valid/ready. It then drives the program counter's load/incr controls from the branch decision. It also provides run/single-step debug control and a sticky ROM-timeout fault.

## Interface
- DATA_WIDTH, 16, width of PC, ROM address and instruction
- TIMEOUT_CYCLES, 255, consecutive unacknowledged fetch cycles before fault (≥2)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; high = fetch/issue continuously
- step  in  1  single-cycle pulse; fetch/issue exactly one instruction when halted
- fault_clr  in  1  pulse; leaves FAULT state
- pc_value  in  DATA_WIDTH  current program counter output
- pc_load  out  1  program counter load strobe
- pc_incr  out  1  program counter increment strobe
- pc_in  out  DATA_WIDTH  program counter load value
- rom_req  out  1  fetch request
- rom_addr  out  DATA_WIDTH  fetch address, equals pc_value
- rom_ack  in  1  fetch data valid; may be same cycle as rom_req
- rom_data  in  DATA_WIDTH  fetched instruction
- instr_valid  out  1  instruction offered to execute
- instr  out  DATA_WIDTH  registered instruction
- instr_ready  in  1  execute accepts instruction
- br_taken  in  1  jump taken; sampled only on issue handshake
- br_target  in  DATA_WIDTH  jump target; sampled with br_taken
- halted  out  1  high in IDLE
- fault  out  1  high in FAULT

## Operation
- States: IDLE, FETCH, ISSUE, FAULT.
- IDLE:
  - halted=1.
  - run=1 → FETCH.
  - Otherwise step=1 → FETCH with one-shot flag set.
  - step is ignored in every other state and is never queued.
- FETCH:
  - rom_req=1, rom_addr=pc_value (combinational).
  - rom_ack=1 → capture rom_data into instr, clear wait counter, go to ISSUE.
  - Each cycle without ack increments the wait counter. When the count reaches TIMEOUT_CYCLES → FAULT.
  - An ack in the final allowed cycle wins over the timeout.
- ISSUE:
  - instr_valid=1; instr held stable until the handshake.
  - On instr_valid&&instr_ready (combinational, same cycle):
    - br_taken=1 → pc_load=1, pc_in=br_target.
    - br_taken=0 → pc_incr=1.
    - Never both at once.
  - Next state: FETCH if run=1 and the one-shot flag is clear; else IDLE (one-shot flag cleared).
- run falling mid-instruction: the current fetch/issue completes, then IDLE. Never abandon a fetched instruction.
- FAULT:
  - All strobes low; fault=1; instr holds its last value.
  - fault_clr → IDLE.
  - run/step ignored.
- PC wrap 0xFFFF→0x0000 is the counter's concern; no special handling.
- pc_in=0 whenever pc_load=0.

## Timing
- Reset (asynchronous, rst=0):
  - state IDLE, halted=1.
  - rom_req, instr_valid, pc_load, pc_incr, fault = 0.
  - instr=0, pc_in=0, wait counter=0, one-shot flag=0.
- Reset mid-operation drops any outstanding rom_req immediately. The program counter is not driven and keeps its own reset.
- IDLE→FETCH: one edge after run/step is sampled high.
- Zero-wait ROM with always-ready execute: 2 cycles per instruction (FETCH, ISSUE), steady state.
- PC update on the edge ending the issue handshake cycle. The following FETCH presents the new pc_value.
- N ROM wait cycles add N cycles. Each execute stall cycle adds 1.
- FAULT entered on the edge after the TIMEOUT_CYCLES-th unacked FETCH cycle. fault_clr exits on the next edge.

## Structure
- Package hack_seq_pkg holds:
  - seq_state_t enum (IDLE, FETCH, ISSUE, FAULT), 2-bit.
  - Default DATA_WIDTH and TIMEOUT_CYCLES constants.
- Sub-module hack_wait_timer holds:
  - Saturating counter of width $clog2(TIMEOUT_CYCLES+1).
  - Inputs: enable, clear. Output: expired.
- The top-level module holds the FSM, instr register and one-shot flag.

## Test plan
- Reset, run=1, zero-wait ROM, instr_ready=1, br_taken=0 → pc_incr pulses every 2nd cycle; rom_addr sequence 0,1,2,3.
- ISSUE with br_taken=1, br_target=0x0040 → pc_load=1, pc_in=0x0040, pc_incr=0; next rom_addr=0x0040.
- run=0, step pulse in IDLE → exactly one rom_req handshake and one pc_incr, then halted=1. A second step asserted during FETCH is ignored.
- TIMEOUT_CYCLES=4, rom_ack held low → fault=1 after 4 FETCH cycles, rom_req drops. Ack on the 4th cycle instead → ISSUE, no fault. fault_clr → halted=1.
- instr_ready low for 3 ISSUE cycles → instr_valid held and instr stable, no PC strobe until ready; rst pulse during FETCH → rom_req=0 immediately, halted=1.
